// File: rtl/ltssm_pkg.sv
// Shared substate codes, ordered-set types and TX LTSSM FSM states.
// Also holds the per-substate ordered-set selection used by master_tx_ltssm.
package ltssm_pkg;

    typedef enum logic [3:0] {
        SUB_DETECT_QUIET   = 4'd0,
        SUB_DETECT_ACTIVE  = 4'd1,
        SUB_POLL_ACTIVE    = 4'd2,
        SUB_POLL_CONFIG    = 4'd3,
        SUB_LW_START       = 4'd4,
        SUB_LW_ACCEPT      = 4'd5,
        SUB_LN_WAIT        = 4'd6,
        SUB_LN_ACCEPT      = 4'd7,
        SUB_CFG_COMPLETE   = 4'd8,
        SUB_CFG_IDLE       = 4'd9,
        SUB_L0             = 4'd10
    } substate_e;

    typedef enum logic [2:0] {
        OS_NONE  = 3'd0,
        OS_TS1   = 3'd1,
        OS_TS2   = 3'd2,
        OS_IDLE  = 3'd3,
        OS_EIEOS = 3'd5
    } os_type_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_DRAIN,
        TX_DONE
    } tx_state_e;

    typedef struct packed {
        logic [2:0] os_type;
        logic       pad;
    } os_sel_t;

    localparam int POLL_ACTIVE_MIN_DEF = 1024;
    localparam int POST_RX_COUNT_DEF   = 16;
    localparam int EIEOS_INTERVAL      = 32;

    function automatic os_sel_t os_select(input logic [3:0] sub);
        os_sel_t s;
        s.os_type = OS_NONE;
        s.pad     = 1'b0;
        case (sub)
            SUB_POLL_ACTIVE, SUB_LW_START: begin
                s.os_type = OS_TS1;
                s.pad     = 1'b1;
            end
            SUB_POLL_CONFIG: begin
                s.os_type = OS_TS2;
                s.pad     = 1'b1;
            end
            SUB_LW_ACCEPT, SUB_LN_WAIT, SUB_LN_ACCEPT: s.os_type = OS_TS1;
            SUB_CFG_COMPLETE:                          s.os_type = OS_TS2;
            SUB_CFG_IDLE:                              s.os_type = OS_IDLE;
            default: ;
        endcase
        return s;
    endfunction

    // Substates that keep transmitting a fixed number of sets after RX completes.
    function automatic logic drains_after_rx(input logic [3:0] sub);
        return (sub == SUB_POLL_CONFIG) || (sub == SUB_CFG_COMPLETE) || (sub == SUB_CFG_IDLE);
    endfunction

    function automatic logic is_polling(input logic [3:0] sub);
        return (sub == SUB_POLL_ACTIVE) || (sub == SUB_POLL_CONFIG);
    endfunction

endpackage

// File: rtl/ltssm_tx_os_counter.sv
// Saturating up-counter with synchronous clear (priority) and increment enable.
module ltssm_tx_os_counter #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/master_tx_ltssm.sv
// TX-side LTSSM master: requests ordered sets per substate, counts acks, reports finish/exitTo.
// Optional EIEOS insertion in Polling substates is enabled by defining TX_EIEOS_INSERT_EN.
module master_tx_ltssm
    import ltssm_pkg::*;
#(
    parameter int MAXLANES        = 16,
    parameter int POLL_ACTIVE_MIN = POLL_ACTIVE_MIN_DEF,
    parameter int POST_RX_COUNT   = POST_RX_COUNT_DEF,
    parameter int CNT_W           = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          substate_i,
    input  logic                rxFinish_i,
    input  logic [3:0]          rxExitTo_i,
    input  logic                timeOut_i,
    input  logic                osAck_i,
    output logic                osValid_o,
    output logic [2:0]          osType_o,
    output logic                padLinkLane_o,
    output logic [MAXLANES-1:0] txElecIdle_o,
    output logic                finish_o,
    output logic [3:0]          exitTo_o
);

    tx_state_e           state_q;
    logic [3:0]          last_sub_q;
    logic                rx_seen_q;
    logic                os_valid_q;
    logic [2:0]          os_type_q;
    logic                pad_q;
    logic [MAXLANES-1:0] elec_idle_q;
    logic                finish_q;
    logic [3:0]          exit_to_q;

    logic [CNT_W-1:0]    sent_cnt;
    logic [CNT_W-1:0]    drain_cnt;
    logic                in_tx;
    logic                sub_changed;
    logic                restart;
    logic                eieos_active;
    logic                ts_ack;
    logic                sent_inc;
    logic                drain_inc;
    logic                rx_ok;
    logic                rx_fail;
    logic                drain_done;
    logic                sent_enough;
    os_sel_t             sel_new;

`ifdef TX_EIEOS_INSERT_EN
    localparam int EI_W = $clog2(EIEOS_INTERVAL);
    logic            eieos_q;
    logic [EI_W-1:0] eieos_mod_q;
    os_sel_t         sel_cur;
    assign eieos_active = eieos_q;
    assign sel_cur      = os_select(last_sub_q);
`else
    assign eieos_active = 1'b0;
`endif

    assign in_tx       = (state_q == TX_SEND) || (state_q == TX_DRAIN);
    assign sub_changed = (substate_i != last_sub_q);
    // Entry from IDLE and a mid-transmit substate change both start a fresh SEND.
    assign restart     = (substate_i > SUB_DETECT_ACTIVE) &&
                         ((state_q == TX_IDLE) || (in_tx && sub_changed));
    assign ts_ack      = in_tx && osAck_i && !eieos_active;
    assign sent_inc    = (state_q == TX_SEND) && ts_ack;
    assign drain_inc   = (state_q == TX_DRAIN) && ts_ack;
    assign rx_ok       = rxFinish_i && (rxExitTo_i != 4'd0);
    assign rx_fail     = rxFinish_i && (rxExitTo_i == 4'd0);
    assign drain_done  = drain_inc && (drain_cnt == CNT_W'(POST_RX_COUNT - 1));
    assign sent_enough = (sent_cnt >= CNT_W'(POLL_ACTIVE_MIN));
    assign sel_new     = os_select(substate_i);

    ltssm_tx_os_counter #(.W(CNT_W)) u_sent_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (restart),
        .inc_i (sent_inc),
        .cnt_o (sent_cnt)
    );

    ltssm_tx_os_counter #(.W(CNT_W)) u_drain_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (restart),
        .inc_i (drain_inc),
        .cnt_o (drain_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= TX_IDLE;
            last_sub_q  <= SUB_DETECT_QUIET;
            rx_seen_q   <= 1'b0;
            os_valid_q  <= 1'b0;
            os_type_q   <= OS_NONE;
            pad_q       <= 1'b0;
            elec_idle_q <= '1;
            finish_q    <= 1'b0;
            exit_to_q   <= 4'd0;
`ifdef TX_EIEOS_INSERT_EN
            eieos_q     <= 1'b0;
            eieos_mod_q <= '0;
`endif
        end else begin
            finish_q <= 1'b0;
            if (restart) begin
                state_q     <= TX_SEND;
                last_sub_q  <= substate_i;
                rx_seen_q   <= 1'b0;
                os_valid_q  <= 1'b1;
                os_type_q   <= sel_new.os_type;
                pad_q       <= sel_new.pad;
                elec_idle_q <= '0;
`ifdef TX_EIEOS_INSERT_EN
                eieos_q     <= 1'b0;
                eieos_mod_q <= '0;
`endif
            end else begin
                case (state_q)
                    TX_IDLE: begin
                        os_valid_q  <= 1'b0;
                        elec_idle_q <= '1;
                    end
                    TX_SEND, TX_DRAIN: begin
`ifdef TX_EIEOS_INSERT_EN
                        if (osAck_i) begin
                            if (eieos_q) begin
                                eieos_q   <= 1'b0;
                                os_type_q <= sel_cur.os_type;
                                pad_q     <= sel_cur.pad;
                            end else if (is_polling(last_sub_q)) begin
                                if (eieos_mod_q == EI_W'(EIEOS_INTERVAL - 1)) begin
                                    eieos_mod_q <= '0;
                                    eieos_q     <= 1'b1;
                                    os_type_q   <= OS_EIEOS;
                                    pad_q       <= 1'b1;
                                end else begin
                                    eieos_mod_q <= eieos_mod_q + 1'b1;
                                end
                            end
                        end
`endif
                        if (rx_ok) begin
                            rx_seen_q <= 1'b1;
                        end
                        if (sub_changed) begin
                            // Only reachable when the new substate is a Detect substate.
                            state_q     <= TX_IDLE;
                            last_sub_q  <= substate_i;
                            rx_seen_q   <= 1'b0;
                            os_valid_q  <= 1'b0;
                            elec_idle_q <= '1;
                        end else if (timeOut_i || rx_fail) begin
                            state_q    <= TX_DONE;
                            os_valid_q <= 1'b0;
                            finish_q   <= 1'b1;
                            exit_to_q  <= 4'd0;
                        end else if (state_q == TX_DRAIN) begin
                            if (drain_done) begin
                                state_q    <= TX_DONE;
                                os_valid_q <= 1'b0;
                                finish_q   <= 1'b1;
                                exit_to_q  <= last_sub_q + 4'd1;
                            end
                        end else if (rx_seen_q) begin
                            if (last_sub_q == SUB_POLL_ACTIVE) begin
                                if (sent_enough) begin
                                    state_q    <= TX_DONE;
                                    os_valid_q <= 1'b0;
                                    finish_q   <= 1'b1;
                                    exit_to_q  <= last_sub_q + 4'd1;
                                end
                            end else if (drains_after_rx(last_sub_q)) begin
                                state_q <= TX_DRAIN;
                            end else begin
                                state_q    <= TX_DONE;
                                os_valid_q <= 1'b0;
                                finish_q   <= 1'b1;
                                exit_to_q  <= last_sub_q + 4'd1;
                            end
                        end
                    end
                    default: state_q <= TX_IDLE;
                endcase
            end
        end
    end

    assign osValid_o     = os_valid_q;
    assign osType_o      = os_type_q;
    assign padLinkLane_o = pad_q;
    assign txElecIdle_o  = elec_idle_q;
    assign finish_o      = finish_q;
    assign exitTo_o      = exit_to_q;

endmodule

// File: tb/tb_master_tx_ltssm.sv
// Self-checking bench for master_tx_ltssm: table of directed/random transactions plus corner sequences.
module tb_master_tx_ltssm;

    localparam int LANES = 16;
    localparam int NO_EVT = 100000;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       substate;
    logic             rxFinish;
    logic [3:0]       rxExitTo;
    logic             timeOut;
    logic             osAck;
    logic             osValid;
    logic [2:0]       osType;
    logic             padLinkLane;
    logic [LANES-1:0] txElecIdle;
    logic             finish;
    logic [3:0]       exitTo;

    always #5 clk = ~clk;

    master_tx_ltssm #(.MAXLANES(LANES)) dut (
        .clk           (clk),
        .reset         (reset),
        .substate_i    (substate),
        .rxFinish_i    (rxFinish),
        .rxExitTo_i    (rxExitTo),
        .timeOut_i     (timeOut),
        .osAck_i       (osAck),
        .osValid_o     (osValid),
        .osType_o      (osType),
        .padLinkLane_o (padLinkLane),
        .txElecIdle_o  (txElecIdle),
        .finish_o      (finish),
        .exitTo_o      (exitTo)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        int sub;
        int k;         // TS acks before rxFinish
        int rx_exit;
        int tmo;       // TS acks before timeOut, -1 for none
        int exp_os;
        int exp_pad;
        int exp_exit;
        int exp_acks;  // TS acks counted up to finish
    } case_t;

    case_t cases[$];

    // Reference model derived from the transaction-level rules.
    function automatic case_t model(input int sub, input int k, input int rx_exit, input int tmo);
        case_t c;
        c.sub = sub; c.k = k; c.rx_exit = rx_exit; c.tmo = tmo;
        case (sub)
            2, 4:    begin c.exp_os = 1; c.exp_pad = 1; end
            3:       begin c.exp_os = 2; c.exp_pad = 1; end
            5, 6, 7: begin c.exp_os = 1; c.exp_pad = 0; end
            8:       begin c.exp_os = 2; c.exp_pad = 0; end
            default: begin c.exp_os = 3; c.exp_pad = 0; end
        endcase
        if (tmo >= 0) begin
            c.exp_exit = 0; c.exp_acks = tmo;
        end else if (rx_exit == 0) begin
            c.exp_exit = 0; c.exp_acks = k;
        end else begin
            c.exp_exit = sub + 1;
            if (sub == 2)                          c.exp_acks = (k > 1024) ? k : 1024;
            else if (sub == 3 || sub == 8 || sub == 9) c.exp_acks = k + 16;
            else                                   c.exp_acks = k;
        end
        return c;
    endfunction

    task automatic run_case(input int idx, input case_t c);
        int ts_acks = 0;
        int gap = 0;
        int cyc = 0;
        int os_bad = 0;
        int fin_exit = 0;
        int fin_valid = 0;
        bit expect_eie = 0;
        bit last_ack = 0;
        bit rx_done = 0;
        bit to_done = 0;
        bit got_fin = 0;
        @(negedge clk);
        substate = 4'(c.sub);
        while (cyc < 8000 && !got_fin) begin
            @(negedge clk);
            cyc++;
            osAck = 0; rxFinish = 0; timeOut = 0;
            if (finish) begin
                got_fin = 1; fin_exit = int'(exitTo); fin_valid = int'(osValid);
                substate = 4'd0;
            end else begin
                if (osValid) begin
                    if (int'(osType) != (expect_eie ? 5 : c.exp_os) ||
                        int'(padLinkLane) != (expect_eie ? 1 : c.exp_pad) ||
                        txElecIdle != '0) os_bad++;
                end
                if (last_ack && ts_acks == c.k && !rx_done) begin
                    rxFinish = 1; rxExitTo = 4'(c.rx_exit); rx_done = 1;
                end
                if (last_ack && ts_acks == c.tmo && !to_done) begin
                    timeOut = 1; to_done = 1;
                end
                last_ack = 0;
                if (gap > 0) gap--;
                else if (osValid) begin
                    osAck = 1; last_ack = 1; gap = int'($urandom_range(4, 2));
                    if (expect_eie) expect_eie = 0;
                    else begin
                        ts_acks++;
`ifdef TX_EIEOS_INSERT_EN
                        if ((c.sub == 2 || c.sub == 3) && ts_acks % 32 == 0) expect_eie = 1;
`endif
                    end
                end
            end
        end
        osAck = 0; rxFinish = 0; timeOut = 0; substate = 4'd0;
        $display("case %0d sub=%0d k=%0d tmo=%0d acks=%0d exitTo=%0d fin=%0d",
                 idx, c.sub, c.k, c.tmo, ts_acks, fin_exit, got_fin);
        chk("finish_seen", int'(got_fin), 1);
        if (got_fin) begin
            chk("exitTo", fin_exit, c.exp_exit);
            chk("ack_count", ts_acks, c.exp_acks);
            chk("osValid_in_done", fin_valid, 0);
            chk("os_select_errors", os_bad, 0);
            @(negedge clk);
            chk("finish_one_cycle", int'(finish), 0);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_acks(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (2) @(negedge clk);
            chk("ack_valid", int'(osValid), 1);
            osAck = 1;
            @(negedge clk);
            osAck = 0;
        end
    endtask

    initial begin
        int got;
        reset = 1; substate = 0; rxFinish = 0; rxExitTo = 0; timeOut = 0; osAck = 0;
        repeat (2) @(negedge clk);
        chk("rst_osValid", int'(osValid), 0);
        chk("rst_osType", int'(osType), 0);
        chk("rst_pad", int'(padLinkLane), 0);
        chk("rst_finish", int'(finish), 0);
        chk("rst_exitTo", int'(exitTo), 0);
        chk("rst_elecidle", int'(txElecIdle), 16'hFFFF);
        reset = 0;
        repeat (3) @(negedge clk);
        chk("idle_osValid", int'(osValid), 0);
        chk("idle_elecidle", int'(txElecIdle), 16'hFFFF);

        cases.push_back('{2, 100, 3, -1, 1, 1, 3, 1024});
        cases.push_back('{8, 5, 9, -1, 2, 0, 9, 21});
        cases.push_back('{5, NO_EVT, 6, 3, 1, 0, 0, 3});
        cases.push_back('{6, 4, 0, -1, 1, 0, 0, 4});
        cases.push_back('{9, 3, 10, -1, 3, 0, 10, 19});
        cases.push_back('{3, 7, 4, -1, 2, 1, 4, 23});
        cases.push_back('{4, 2, 5, -1, 1, 1, 5, 2});
        cases.push_back('{7, 1, 8, -1, 1, 0, 8, 1});
        for (int i = 0; i < 8; i++) begin
            int s, k, rx, t;
            s  = int'($urandom_range(9, 3));
            k  = int'($urandom_range(40, 2));
            rx = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(15, 1));
            t  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(k - 1, 1)) : -1;
            cases.push_back(model(s, k, rx, t));
        end
        foreach (cases[i]) run_case(i, cases[i]);

        // Substate change mid-SEND restarts with the new selection and no finish.
        @(negedge clk);
        substate = 4'd3;
        do_acks(10);
        substate = 4'd4;
        @(negedge clk);
        chk("sw_osValid", int'(osValid), 1);
        chk("sw_osType", int'(osType), 1);
        chk("sw_pad", int'(padLinkLane), 1);
        chk("sw_no_finish", int'(finish), 0);
        rxFinish = 1; rxExitTo = 4'd5;
        @(negedge clk);
        rxFinish = 0;
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            if (finish) begin
                got = 1;
                chk("sw_exitTo", int'(exitTo), 5);
            end else @(negedge clk);
        end
        chk("sw_finish_seen", got, 1);
        $display("switch 3->4 finish=%0d exitTo=%0d", got, exitTo);
        substate = 4'd0;
        repeat (3) @(negedge clk);

        // Reset mid-DRAIN in configurationIdle.
        substate = 4'd9;
        do_acks(2);
        rxFinish = 1; rxExitTo = 4'd10;
        @(negedge clk);
        rxFinish = 0;
        do_acks(3);
        @(negedge clk);
        chk("drain_osValid", int'(osValid), 1);
        #1 reset = 1;
        #1;
        chk("mid_rst_osValid", int'(osValid), 0);
        chk("mid_rst_elecidle", int'(txElecIdle), 16'hFFFF);
        chk("mid_rst_finish", int'(finish), 0);
        chk("mid_rst_osType", int'(osType), 0);
        $display("reset mid-drain osValid=%0d txElecIdle=%h", osValid, txElecIdle);
        @(negedge clk);
        reset = 0; substate = 4'd0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
